uart_rx_vote_sampler: RTL and testbench

//  Parametrised oversampling majority-vote bit sampler for the UART RX path.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/rx_sync.sv | 29 ++
 rtl/uart_rx_vote_sampler.sv | 157 +++++++++++++++
 tb/tb_uart_rx_vote_sampler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants, types and helpers for the UART RX vote sampler.
package uart_rx_pkg;

    localparam int PRESC_W_DEF  = 6;
    localparam int MAX_SAMPLES  = 7;
    localparam int CNT_W        = 3;
    localparam int MAX_SYNC     = 3;

    typedef struct packed {
        logic value;
        logic valid;
        logic noise;
    } vote_out_t;

    localparam vote_out_t VOTE_OUT_RST = '{value: 1'b1, valid: 1'b0, noise: 1'b0};

    // Smallest prescale that fits the window plus a vote slot before the bit ends.
    function automatic int min_prescale(input int n);
        return n + 2;
    endfunction

    function automatic logic majority(input logic [CNT_W-1:0] ones, input int n);
        return (int'(ones) > (n / 2));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != {CNT_W{1'b1}})) begin
            return c + 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Reset-to-idle (1) synchroniser for the RX line; STAGES=0 is a plain wire.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= STAGES'({sync_q, d_i});
                end
            end

            assign q_o = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler for the UART RX path.
// Define UART_RX_NOISE_DET_EN to enable the noise_err strobe (otherwise tied low).
module uart_rx_vote_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W     = PRESC_W_DEF,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               rx_in,
    input  logic               enable,
    input  logic [PRESC_W-1:0] edge_count,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               noise_err,
    output logic               cfg_err
);

    localparam int             EW   = PRESC_W + 1;
    localparam logic [EW-1:0]  HALF = EW'(NUM_SAMPLES / 2);
    localparam logic [CNT_W:0] NS   = (CNT_W + 1)'(NUM_SAMPLES);

    generate
        if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > MAX_SAMPLES) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_samples
            $error("uart_rx_vote_sampler: NUM_SAMPLES must be odd and within 1..7");
        end
        if ((SYNC_STAGES < 0) || (SYNC_STAGES > MAX_SYNC)) begin : g_bad_sync
            $error("uart_rx_vote_sampler: SYNC_STAGES must be within 0..3");
        end
    endgenerate

    logic rx_s;

    rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rx_in),
        .q_o  (rx_s)
    );

    // Window decode in one extra bit so centre+half never wraps.
    logic [EW-1:0] psc_x;
    logic [EW-1:0] ec_x;
    logic [EW-1:0] centre;
    logic [EW-1:0] win_start;
    logic [EW-1:0] win_end;
    logic [EW-1:0] vote_pt;
    logic          cfg_bad;
    logic          in_win;
    logic          at_vote;

    assign psc_x     = {1'b0, prescale};
    assign ec_x      = {1'b0, edge_count};
    assign centre    = psc_x >> 1;
    assign win_start = centre - HALF;
    assign win_end   = centre + HALF;
    assign vote_pt   = win_end + EW'(1);
    assign cfg_bad   = (centre < HALF) || (vote_pt >= psc_x);
    assign in_win    = (ec_x >= win_start) && (ec_x <= win_end);
    assign at_vote   = (ec_x == vote_pt);

    logic cfg_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_bad;
        end
    end

    logic             active;
    logic             clr;
    logic             cap;
    logic             vote;
    logic [CNT_W:0]   total;
    logic             noise_hit;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_d;

    assign active = enable && !cfg_err_q;
    // A vote slot also closes the window, so a stalled edge_count cannot double-strobe.
    assign clr    = !active || (ec_x == '0) || at_vote;
    assign cap    = active && in_win && !clr;
    assign vote   = active && at_vote && (total == NS);
    assign ones_d = clr ? '0 : sat_inc(ones_q, cap && rx_s);

`ifdef UART_RX_NOISE_DET_EN
    logic [CNT_W-1:0] zeros_q;
    logic [CNT_W-1:0] zeros_d;

    assign zeros_d   = clr ? '0 : sat_inc(zeros_q, cap && !rx_s);
    assign total     = {1'b0, ones_q} + {1'b0, zeros_q};
    assign noise_hit = (ones_q != '0) && (zeros_q != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ones_q  <= '0;
            zeros_q <= '0;
        end else begin
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
        end
    end
`else
    // Without noise detection only the sample count is needed for the full-window check.
    logic [CNT_W-1:0] smp_q;
    logic [CNT_W-1:0] smp_d;

    assign smp_d     = clr ? '0 : sat_inc(smp_q, cap);
    assign total     = {1'b0, smp_q};
    assign noise_hit = 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ones_q <= '0;
            smp_q  <= '0;
        end else begin
            ones_q <= ones_d;
            smp_q  <= smp_d;
        end
    end
`endif

    vote_out_t out_q;
    vote_out_t out_d;

    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        out_d.noise = 1'b0;
        if (vote) begin
            out_d.value = majority(ones_q, NUM_SAMPLES);
            out_d.valid = 1'b1;
            out_d.noise = noise_hit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= VOTE_OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign sampled_bit  = out_q.value;
    assign sample_valid = out_q.valid;
    assign noise_err    = out_q.noise;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Directed bench: three sampler instances (N=3/SYNC=0, N=5/SYNC=0, N=3/SYNC=2) on a shared line.
module tb_uart_rx_vote_sampler;

`ifdef UART_RX_NOISE_DET_EN
    localparam logic NOISE_EN = 1'b1;
`else
    localparam logic NOISE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_in;
    logic       enable;
    logic [5:0] edge_count;
    logic [5:0] psc_a, psc_b, psc_c;
    logic       bit_a, vld_a, nz_a, cfg_a;
    logic       bit_b, vld_b, nz_b, cfg_b;
    logic       bit_c, vld_c, nz_c, cfg_c;

    int   checks = 0;
    int   errors = 0;
    int   cnt_a, cnt_b, cnt_c;
    int   at_a, at_b, at_c;
    logic last_a, last_b, last_c;
    logic nzl_a, nzl_b, nzl_c;
    logic rs_bit, rs_vld, rs_nz, rs_cfg;

    always #5 clk = ~clk;

    uart_rx_vote_sampler #(.PRESC_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(0)) dut_a (
        .clk(clk), .rstn(rstn), .prescale(psc_a), .rx_in(rx_in), .enable(enable),
        .edge_count(edge_count), .sampled_bit(bit_a), .sample_valid(vld_a),
        .noise_err(nz_a), .cfg_err(cfg_a));

    uart_rx_vote_sampler #(.PRESC_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(0)) dut_b (
        .clk(clk), .rstn(rstn), .prescale(psc_b), .rx_in(rx_in), .enable(enable),
        .edge_count(edge_count), .sampled_bit(bit_b), .sample_valid(vld_b),
        .noise_err(nz_b), .cfg_err(cfg_b));

    uart_rx_vote_sampler #(.PRESC_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .rstn(rstn), .prescale(psc_c), .rx_in(rx_in), .enable(enable),
        .edge_count(edge_count), .sampled_bit(bit_c), .sample_valid(vld_c),
        .noise_err(nz_c), .cfg_err(cfg_c));

    // One bit period: edge_count 0..len-1, rx from pat[k]; optional enable drop / reset pulse.
    task automatic run_bit(input int len, input logic [15:0] pat, input int drop_at, input int rst_at);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        at_a = -1; at_b = -1; at_c = -1;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (vld_a) begin cnt_a++; last_a = bit_a; nzl_a = nz_a; at_a = k - 1; end
            if (vld_b) begin cnt_b++; last_b = bit_b; nzl_b = nz_b; at_b = k - 1; end
            if (vld_c) begin cnt_c++; last_c = bit_c; nzl_c = nz_c; at_c = k - 1; end
            if (k < len) begin
                edge_count = 6'(k);
                rx_in      = pat[k];
                enable     = (drop_at < 0) || (k < drop_at);
                if (k == rst_at) begin
                    rstn = 1'b0;
                    #1;
                    rs_bit = bit_a; rs_vld = vld_a; rs_nz = nz_a; rs_cfg = cfg_a;
                end else if (k == rst_at + 1) begin
                    rstn = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx_in = 1'b1; enable = 1'b0; edge_count = '0;
        psc_a = 6'd8; psc_b = 6'd16; psc_c = 6'd8;
        repeat (2) @(negedge clk);
        checks++; if (bit_a !== 1'b1) begin errors++; $display("FAIL reset_bit: got %b want 1", bit_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld_a); end
        checks++; if (nz_a !== 1'b0) begin errors++; $display("FAIL reset_noise: got %b want 0", nz_a); end
        checks++; if (cfg_a !== 1'b0) begin errors++; $display("FAIL reset_cfg: got %b want 0", cfg_a); end
        checks++; if (bit_c !== 1'b1) begin errors++; $display("FAIL reset_bit_sync2: got %b want 1", bit_c); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cfg_b !== 1'b0) begin errors++; $display("FAIL cfg_ok_n5: got %b want 0", cfg_b); end
    endtask

    task automatic test_vote_n3();
        run_bit(8, 16'hFFEF, -1, -1);
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL n3_101_count: got %0d want 1", cnt_a); end
        checks++; if (at_a !== 6) begin errors++; $display("FAIL n3_101_latency: got %0d want 6", at_a); end
        checks++; if (last_a !== 1'b1) begin errors++; $display("FAIL n3_101_bit: got %b want 1", last_a); end
        checks++; if (nzl_a !== NOISE_EN) begin errors++; $display("FAIL n3_101_noise: got %b want %b", nzl_a, NOISE_EN); end
        run_bit(8, 16'h0000, -1, -1);
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL n3_000_count: got %0d want 1", cnt_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("FAIL n3_000_bit: got %b want 0", last_a); end
        checks++; if (nzl_a !== 1'b0) begin errors++; $display("FAIL n3_000_noise: got %b want 0", nzl_a); end
        checks++; if (bit_a !== 1'b0) begin errors++; $display("FAIL n3_000_hold: got %b want 0", bit_a); end
    endtask

    task automatic test_vote_n5();
        run_bit(16, 16'hFB3F, -1, -1);
        checks++; if (cnt_b !== 1) begin errors++; $display("FAIL n5_mixed_count: got %0d want 1", cnt_b); end
        checks++; if (at_b !== 11) begin errors++; $display("FAIL n5_mixed_latency: got %0d want 11", at_b); end
        checks++; if (last_b !== 1'b0) begin errors++; $display("FAIL n5_mixed_bit: got %b want 0", last_b); end
        checks++; if (nzl_b !== NOISE_EN) begin errors++; $display("FAIL n5_mixed_noise: got %b want %b", nzl_b, NOISE_EN); end
        run_bit(16, 16'hFFFF, -1, -1);
        checks++; if (cnt_b !== 1) begin errors++; $display("FAIL n5_ones_count: got %0d want 1", cnt_b); end
        checks++; if (last_b !== 1'b1) begin errors++; $display("FAIL n5_ones_bit: got %b want 1", last_b); end
        checks++; if (nzl_b !== 1'b0) begin errors++; $display("FAIL n5_ones_noise: got %b want 0", nzl_b); end
    endtask

    task automatic test_cfg_err();
        int total;
        @(negedge clk);
        psc_a = 6'd4;
        #1;
        checks++; if (cfg_a !== 1'b0) begin errors++; $display("FAIL cfg_lag: got %b want 0", cfg_a); end
        @(negedge clk);
        checks++; if (cfg_a !== 1'b1) begin errors++; $display("FAIL cfg_set: got %b want 1", cfg_a); end
        total = 0;
        run_bit(8, 16'h0000, -1, -1); total += cnt_a;
        run_bit(8, 16'hFFFF, -1, -1); total += cnt_a;
        run_bit(8, 16'h0000, -1, -1); total += cnt_a;
        checks++; if (total !== 0) begin errors++; $display("FAIL cfg_no_strobe: got %0d want 0", total); end
        checks++; if (cfg_a !== 1'b1) begin errors++; $display("FAIL cfg_held: got %b want 1", cfg_a); end
        psc_a = 6'd8;
        run_bit(8, 16'hFFFF, -1, -1);
        checks++; if (cfg_a !== 1'b0) begin errors++; $display("FAIL cfg_clear: got %b want 0", cfg_a); end
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL cfg_recover_count: got %0d want 1", cnt_a); end
        checks++; if (last_a !== 1'b1) begin errors++; $display("FAIL cfg_recover_bit: got %b want 1", last_a); end
    endtask

    task automatic test_enable_drop();
        run_bit(8, 16'hFFFF, -1, -1);
        run_bit(8, 16'h0000, 4, -1);
        checks++; if (cnt_a !== 0) begin errors++; $display("FAIL en_drop_count: got %0d want 0", cnt_a); end
        checks++; if (bit_a !== 1'b1) begin errors++; $display("FAIL en_drop_hold: got %b want 1", bit_a); end
        run_bit(8, 16'h0000, -1, -1);
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL en_resume_count: got %0d want 1", cnt_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("FAIL en_resume_bit: got %b want 0", last_a); end
    endtask

    task automatic test_reset_mid();
        run_bit(8, 16'h0000, -1, 4);
        checks++; if (rs_bit !== 1'b1) begin errors++; $display("FAIL rst_mid_bit: got %b want 1", rs_bit); end
        checks++; if (rs_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", rs_vld); end
        checks++; if (rs_nz !== 1'b0) begin errors++; $display("FAIL rst_mid_noise: got %b want 0", rs_nz); end
        checks++; if (rs_cfg !== 1'b0) begin errors++; $display("FAIL rst_mid_cfg: got %b want 0", rs_cfg); end
        checks++; if (cnt_a !== 0) begin errors++; $display("FAIL rst_mid_no_strobe: got %0d want 0", cnt_a); end
        run_bit(8, 16'h0000, -1, -1);
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL rst_after_count: got %0d want 1", cnt_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("FAIL rst_after_bit: got %b want 0", last_a); end
    endtask

    task automatic test_sync_delay();
        // Line low at edges 1..3: the 2-stage copy sees 0 across window 3..5, the direct copy sees 0,1,1.
        run_bit(8, 16'hFFF1, -1, -1);
        checks++; if (cnt_c !== 1) begin errors++; $display("FAIL sync2_count: got %0d want 1", cnt_c); end
        checks++; if (at_c !== 6) begin errors++; $display("FAIL sync2_latency: got %0d want 6", at_c); end
        checks++; if (last_c !== 1'b0) begin errors++; $display("FAIL sync2_bit: got %b want 0", last_c); end
        checks++; if (nzl_c !== 1'b0) begin errors++; $display("FAIL sync2_noise: got %b want 0", nzl_c); end
        checks++; if (last_a !== 1'b1) begin errors++; $display("FAIL sync0_bit: got %b want 1", last_a); end
        checks++; if (nzl_a !== NOISE_EN) begin errors++; $display("FAIL sync0_noise: got %b want %b", nzl_a, NOISE_EN); end
    endtask

    initial begin
        test_reset();
        test_vote_n3();
        test_vote_n5();
        test_cfg_err();
        test_enable_drop();
        test_reset_mid();
        test_sync_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
